tour_cmd_sequencer: RTL

- Sits between the tour solver and the motion controller and sequences the solved tour into motion commands.
- Once the solver's move table is ready, it walks the table index 0..NUM_MOVES-1, reading one one-hot move per index.
- It splits each knight move into a vertical leg command followed by a horizontal leg command.
- It also arbitrates the single motion-command channel between the tour and externally issued host commands, and reports completion on a response port.

---
 rtl/tour_cmd_sequencer_if.sv | 30 +++
 rtl/tour_cmd_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd_sequencer_if.sv
// Bus between the tour command sequencer and its neighbours: the solver's
// move table, the host command port, the motion channel and the response port.
interface tour_cmd_sequencer_if #(
  parameter int CMD_W = 16
);
  logic             start_tour;
  logic [7:0]       move;
  logic [4:0]       indx;
  logic [CMD_W-1:0] ext_cmd;
  logic             ext_cmd_vld;
  logic             ext_cmd_clr;
  logic [CMD_W-1:0] cmd;
  logic             cmd_vld;
  logic             cmd_ack;
  logic             tour_active;
  logic [7:0]       resp;
  logic             resp_vld;

  // Sequencer side
  modport master (
    input  start_tour, move, ext_cmd, ext_cmd_vld, cmd_ack,
    output indx, ext_cmd_clr, cmd, cmd_vld, tour_active, resp, resp_vld
  );

  // Environment side (solver, host, motion controller)
  modport slave (
    output start_tour, move, ext_cmd, ext_cmd_vld, cmd_ack,
    input  indx, ext_cmd_clr, cmd, cmd_vld, tour_active, resp, resp_vld
  );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Walks the solved knight's tour table, splits every knight move into a
// vertical and a horizontal motion command, and shares the single motion
// channel with host-issued commands. Completion is reported on resp.
module tour_cmd_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int CMD_W     = 16
) (
  input logic                  clk,
  input logic                  rst,
  tour_cmd_sequencer_if.master bus
);

  localparam int             IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [7:0]     RESP_OK  = 8'hA5;
  localparam logic [7:0]     RESP_BAD = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERT,
    ST_HORZ,
    ST_EXT
  } state_t;

  // Leg command for one move bit: vertical legs use opcode 2 and move |dy|
  // squares north/south, horizontal legs use opcode 3 and move |dx| squares
  // east/west.
  function automatic logic [15:0] leg_cmd(input int bit_idx, input logic horiz);
    int dx;
    int dy;
    case (bit_idx)
      0:       begin dx =  1; dy =  2; end
      1:       begin dx = -1; dy =  2; end
      2:       begin dx = -2; dy =  1; end
      3:       begin dx = -2; dy = -1; end
      4:       begin dx = -1; dy = -2; end
      5:       begin dx =  1; dy = -2; end
      6:       begin dx =  2; dy = -1; end
      7:       begin dx =  2; dy =  1; end
      default: begin dx =  0; dy =  0; end
    endcase
    if (horiz) begin
      leg_cmd = {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    end else begin
      leg_cmd = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    end
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] indx_q, indx_d;
  logic [7:0]       move_q, move_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_vld_q, cmd_vld_d;
  logic             ext_clr_q, ext_clr_d;
  logic             active_q, active_d;
  logic [7:0]       resp_q, resp_d;
  logic             resp_vld_q, resp_vld_d;

  logic [15:0] vert_terms [8];
  logic [15:0] horz_terms [8];
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;
  logic        move_onehot;
  logic        ack_hit;

  // The vertical leg comes straight from the live table entry (issued in LOAD),
  // the horizontal leg from the latched copy so it cannot drift while VERT waits.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_leg
      localparam logic [15:0] VERT_LEG = leg_cmd(gi, 1'b0);
      localparam logic [15:0] HORZ_LEG = leg_cmd(gi, 1'b1);
      assign vert_terms[gi] = bus.move[gi] ? VERT_LEG : 16'h0000;
      assign horz_terms[gi] = move_q[gi]   ? HORZ_LEG : 16'h0000;
    end
  endgenerate

  // Merge the per-bit legs; a one-hot move selects exactly one term.
  always_comb begin
    vert_cmd = 16'h0000;
    horz_cmd = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      vert_cmd = vert_cmd | vert_terms[i];
      horz_cmd = horz_cmd | horz_terms[i];
    end
  end

  assign move_onehot = (bus.move != 8'h00) && ((bus.move & (bus.move - 8'd1)) == 8'h00);
  // An acknowledge only counts while a command is actually on the channel.
  assign ack_hit     = bus.cmd_ack && cmd_vld_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    indx_d     = indx_q;
    move_d     = move_q;
    cmd_d      = cmd_q;
    cmd_vld_d  = cmd_vld_q;
    ext_clr_d  = 1'b0;
    active_d   = active_q;
    resp_d     = resp_q;
    resp_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_tour) begin
          indx_d   = '0;
          active_d = 1'b1;
          state_d  = ST_LOAD;
        end else if (bus.ext_cmd_vld) begin
          cmd_d     = bus.ext_cmd;
          cmd_vld_d = 1'b1;
          ext_clr_d = 1'b1;
          state_d   = ST_EXT;
        end
      end

      ST_LOAD: begin
        move_d = bus.move;
        if (!move_onehot) begin
          resp_d     = RESP_BAD;
          resp_vld_d = 1'b1;
          active_d   = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cmd_d     = CMD_W'(vert_cmd);
          cmd_vld_d = 1'b1;
          state_d   = ST_VERT;
        end
      end

      ST_VERT: begin
        if (ack_hit) begin
          cmd_d   = CMD_W'(horz_cmd);
          state_d = ST_HORZ;
        end
      end

      ST_HORZ: begin
        if (ack_hit) begin
          cmd_vld_d = 1'b0;
          if (indx_q == LAST_IDX) begin
            resp_d     = RESP_OK;
            resp_vld_d = 1'b1;
            active_d   = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            indx_d  = indx_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end

      ST_EXT: begin
        if (ack_hit) begin
          cmd_vld_d  = 1'b0;
          resp_d     = RESP_OK;
          resp_vld_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      indx_q     <= '0;
      move_q     <= 8'h00;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      ext_clr_q  <= 1'b0;
      active_q   <= 1'b0;
      resp_q     <= 8'h00;
      resp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      indx_q     <= indx_d;
      move_q     <= move_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      ext_clr_q  <= ext_clr_d;
      active_q   <= active_d;
      resp_q     <= resp_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  assign bus.indx        = indx_q;
  assign bus.cmd         = cmd_q;
  assign bus.cmd_vld     = cmd_vld_q;
  assign bus.ext_cmd_clr = ext_clr_q;
  assign bus.tour_active = active_q;
  assign bus.resp        = resp_q;
  assign bus.resp_vld    = resp_vld_q;

endmodule
